// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for DIGITS active-low common-anode seven-segment digits.
// New words are committed only at frame boundaries. Defining SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic                  ready,
    output logic                  ack,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    display;
    logic [4*DIGITS-1:0]    buffer;
    logic                   pending;

    logic                   frame_end_p0;
    logic [3:0]             nib_p0;
    logic                   blank_p0;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Stage 0: pick the nibble for the current digit from the committed word.
    assign frame_end_p0 = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign nib_p0       = display[{idx, 2'b00} +: 4];

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [4*DIGITS-1:0] upper_p0;
    // A digit is a leading zero when it and every digit above it are zero.
    assign upper_p0 = display >> {idx, 2'b00};
    assign blank_p0 = (idx != '0) && (upper_p0 == '0);
`else
    assign blank_p0 = 1'b0;
`endif

    // Stage 1: registered scan state, handshake and pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            display <= '0;
            buffer  <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
            ack     <= 1'b0;
            seg_out <= 7'h7F;
            an      <= '1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            ack <= frame_end_p0 && pending;
            // pending and ready are complementary, so a commit and an accepted load never coincide.
            if (frame_end_p0 && pending) begin
                display <= buffer;
                pending <= 1'b0;
                ready   <= 1'b1;
            end else if (load && ready) begin
                buffer  <= data_in;
                pending <= 1'b1;
                ready   <= 1'b0;
            end

            an      <= ~(DIGITS'(1) << idx);
            seg_out <= blank_p0 ? 7'h7F : hex_to_seg(nib_p0);
        end
    end

endmodule
